// File: rtl/puf_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// puf_ctrl_pkg : FSM encoding, default sizing and vote-width helper for the
//                PUF challenge/response sequencer.            Rev 1.0
// -----------------------------------------------------------------------------
package puf_ctrl_pkg;

    localparam int c_def_width      = 16;
    localparam int c_def_neval      = 3;
    localparam int c_def_settle_cyc = 8;
    localparam int c_def_relax_cyc  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RELAX  = 3'd1,
        ST_FIRE   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_SEND   = 3'd4
    } state_t;

    // Wide enough to hold a count of 0..neval without wrapping.
    function automatic int vote_width(input int neval);
        return $clog2(neval + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_vote_acc.sv
`default_nettype none
// -----------------------------------------------------------------------------
// puf_vote_acc : per-bit vote counters with majority threshold.   Rev 1.0
// -----------------------------------------------------------------------------
module puf_vote_acc
    import puf_ctrl_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int NEVAL = c_def_neval
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc_en,
    input  logic [WIDTH-1:0] bits,
    output logic [WIDTH-1:0] voted
);

    localparam int            c_vw     = vote_width(NEVAL);
    localparam logic [c_vw-1:0] c_thresh = c_vw'((NEVAL - 1) / 2);
    localparam logic [c_vw-1:0] c_max    = c_vw'(NEVAL);

    // voted reflects the count including this cycle's increment, so the final
    // sample is already part of the decision when the caller registers it.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic [c_vw-1:0] r_vote;
            logic [c_vw-1:0] w_vote_nxt;

            always_comb begin
                w_vote_nxt = r_vote;
                if (inc_en && bits[i] && (r_vote != c_max)) begin
                    w_vote_nxt = r_vote + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vote <= '0;
                end else if (clear) begin
                    r_vote <= '0;
                end else begin
                    r_vote <= w_vote_nxt;
                end
            end

            assign voted[i] = (w_vote_nxt > c_thresh);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/puf_crp_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// puf_crp_sequencer : drives NEVAL PUF evaluations per challenge and returns
//                     the majority-voted response to the UART.     Rev 1.0
// -----------------------------------------------------------------------------
module puf_crp_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int WIDTH      = c_def_width,
    parameter int NEVAL      = c_def_neval,
    parameter int SETTLE_CYC = c_def_settle_cyc,
    parameter int RELAX_CYC  = c_def_relax_cyc
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_data,
    output logic [WIDTH-1:0] puf_challenge,
    output logic             puf_trigger,
    input  logic [WIDTH-1:0] puf_response,
    output logic             tx_start,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_done,
    output logic             busy,
    output logic             overrun
);

    localparam int c_ew   = vote_width(NEVAL);
    localparam int c_tmax = (SETTLE_CYC > RELAX_CYC) ? SETTLE_CYC : RELAX_CYC;
    localparam int c_tw   = $clog2(c_tmax + 1);

    localparam logic [c_tw-1:0] c_relax_ld  = c_tw'(RELAX_CYC - 1);
    localparam logic [c_tw-1:0] c_settle_ld = c_tw'(SETTLE_CYC - 1);
    localparam logic [c_ew-1:0] c_neval     = c_ew'(NEVAL);

    state_t           r_state;
    state_t           w_next;
    logic [c_tw-1:0]  r_tmr;
    logic [c_tw-1:0]  w_tmr_nxt;
    logic [c_ew-1:0]  r_eval;
    logic [c_ew-1:0]  w_eval_inc;
    logic [WIDTH-1:0] r_challenge;
    logic [WIDTH-1:0] r_tx_data;
    logic [WIDTH-1:0] w_gray;
    logic [WIDTH-1:0] w_voted;
    logic             r_tx_start;
    logic             w_accept;
    logic             w_sample;
    logic             w_last;
    logic             w_to_send;

    assign w_gray     = rx_data ^ (rx_data >> 1);
    assign w_accept   = (r_state == ST_IDLE) && rx_valid;
    assign w_sample   = (r_state == ST_SAMPLE);
    assign w_eval_inc = r_eval + 1'b1;
    assign w_last     = (w_eval_inc == c_neval);
    assign w_to_send  = w_sample && w_last;

    // One down-counter times both the RELAX and FIRE phases; it is loaded
    // with (length-1) on entry and the phase ends when it reaches zero.
    always_comb begin
        w_next    = r_state;
        w_tmr_nxt = r_tmr;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    w_next    = ST_RELAX;
                    w_tmr_nxt = c_relax_ld;
                end
            end
            ST_RELAX: begin
                if (r_tmr == '0) begin
                    w_next    = ST_FIRE;
                    w_tmr_nxt = c_settle_ld;
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            ST_FIRE: begin
                if (r_tmr == '0) begin
                    w_next = ST_SAMPLE;
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (w_last) begin
                    w_next = ST_SEND;
                end else begin
                    w_next    = ST_RELAX;
                    w_tmr_nxt = c_relax_ld;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tmr       <= '0;
            r_eval      <= '0;
            r_challenge <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tmr      <= w_tmr_nxt;
            r_tx_start <= w_to_send;
            if (w_accept) begin
                r_challenge <= w_gray;
                r_eval      <= '0;
            end else if (w_sample) begin
                r_eval <= w_eval_inc;
            end
            if (w_to_send) begin
                r_tx_data <= w_voted;
            end
        end
    end

    puf_vote_acc #(
        .WIDTH (WIDTH),
        .NEVAL (NEVAL)
    ) u_vote_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_accept),
        .inc_en (w_sample),
        .bits   (puf_response),
        .voted  (w_voted)
    );

    assign puf_challenge = r_challenge;
    assign puf_trigger   = (r_state == ST_FIRE) || (r_state == ST_SAMPLE);
    assign tx_start      = r_tx_start;
    assign tx_data       = r_tx_data;
    assign busy          = (r_state != ST_IDLE);
    assign overrun       = rx_valid && (r_state != ST_IDLE);

endmodule
`default_nettype wire
